// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the hardwired control unit and ALU_System benches.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_FETCH_L = 3'd1,
    ST_FETCH_H = 3'd2,
    ST_EXEC1   = 3'd3,
    ST_EXEC2   = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  // Opcodes, IR[15:12]
  localparam logic [3:0] OP_LDI = 4'h0;
  localparam logic [3:0] OP_LDM = 4'h1;
  localparam logic [3:0] OP_ST  = 4'h2;
  localparam logic [3:0] OP_MOV = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_LSL = 4'hA;
  localparam logic [3:0] OP_LSR = 4'hB;
  localparam logic [3:0] OP_INC = 4'hC;
  localparam logic [3:0] OP_DEC = 4'hD;
  localparam logic [3:0] OP_BNE = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU_FunSel codes
  localparam logic [3:0] ALU_PASS_A = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b0001;
  localparam logic [3:0] ALU_NOT    = 4'b0010;
  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_SUB    = 4'b0101;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_OR     = 4'b1000;
  localparam logic [3:0] ALU_XOR    = 4'b1010;
  localparam logic [3:0] ALU_LSL    = 4'b1011;
  localparam logic [3:0] ALU_LSR    = 4'b1100;

  // Register function selects
  localparam logic [1:0] FUN_CLR  = 2'd0;
  localparam logic [1:0] FUN_LOAD = 2'd1;
  localparam logic [1:0] FUN_DEC  = 2'd2;
  localparam logic [1:0] FUN_INC  = 2'd3;

  // MuxA/MuxB sources
  localparam logic [1:0] MUX_ALU = 2'd0;
  localparam logic [1:0] MUX_MEM = 2'd1;
  localparam logic [1:0] MUX_IMM = 2'd2;
  localparam logic [1:0] MUX_ARF = 2'd3;

  // ARF output selects
  localparam logic [1:0] ARF_AR = 2'd0;
  localparam logic [1:0] ARF_SP = 2'd1;
  localparam logic [1:0] ARF_PC = 2'd3;

  // ARF active-low enables: bit0 PC, bit1 AR, bit2 SP
  localparam logic [3:0] ARF_EN_NONE = 4'hF;
  localparam logic [3:0] ARF_EN_PC   = 4'b1110;
  localparam logic [3:0] ARF_EN_AR   = 4'b1101;
  localparam logic [3:0] ARF_EN_ALL  = 4'b1000;

  typedef struct packed {
    logic [2:0] rf_o1sel;
    logic [2:0] rf_o2sel;
    logic [1:0] rf_funsel;
    logic [1:0] arf_funsel;
    logic [1:0] ir_funsel;
    logic [3:0] rf_regsel;
    logic [3:0] rf_tsel;
    logic [3:0] arf_regsel;
    logic [3:0] alu_funsel;
    logic [1:0] arf_outasel;
    logic [1:0] arf_outbsel;
    logic       ir_lh;
    logic       ir_enable;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_sel_a;
    logic [1:0] mux_sel_b;
    logic       mux_csel;
  } ctrl_t;

  localparam ctrl_t CW_IDLE = '{
    rf_o1sel:    3'd0,
    rf_o2sel:    3'd0,
    rf_funsel:   2'd0,
    arf_funsel:  2'd0,
    ir_funsel:   2'd0,
    rf_regsel:   4'hF,
    rf_tsel:     4'hF,
    arf_regsel:  4'hF,
    alu_funsel:  4'd0,
    arf_outasel: 2'd0,
    arf_outbsel: 2'd0,
    ir_lh:       1'b0,
    ir_enable:   1'b0,
    mem_wr:      1'b0,
    mem_cs:      1'b1,
    mux_sel_a:   2'd0,
    mux_sel_b:   2'd0,
    mux_csel:    1'b0
  };

  // RegFile output select for a 2-bit register field: 4..7 = R1..R4
  function automatic logic [2:0] rf_sel(input logic [1:0] idx);
    return {1'b1, idx};
  endfunction

  // Active-low RegFile enable for a single register field
  function automatic logic [3:0] rf_en(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // ALU operation for the register-to-register opcodes
  function automatic logic [3:0] alu_op_for(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_NOT:  return ALU_NOT;
      OP_LSL:  return ALU_LSL;
      OP_LSR:  return ALU_LSR;
      default: return ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational control-word decode from (state, instruction, Z flag).
module ctrl_decoder
  import cpu_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [15:0] ir,
  input  logic        flag_z,
  output ctrl_t       cw
);

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       unused_ir;

  assign op = ir[15:12];
  assign rd = ir[9:8];
  assign rs = ir[1:0];
  // Immediate/address bits flow through the datapath, not the decoder
  assign unused_ir = ^{ir[11:10], ir[7:2]};

  // Control word: start from idle, then overlay what the state/opcode needs
  always_comb begin
    cw = CW_IDLE;
    case (state)
      ST_INIT: begin
        cw.arf_funsel = FUN_CLR;
        cw.arf_regsel = ARF_EN_ALL;
        cw.rf_funsel  = FUN_CLR;
        cw.rf_regsel  = 4'h0;
      end
      ST_FETCH_L, ST_FETCH_H: begin
        cw.arf_outbsel = ARF_PC;
        cw.mem_cs      = 1'b0;
        cw.ir_enable   = 1'b1;
        cw.ir_funsel   = FUN_LOAD;
        cw.ir_lh       = (state == ST_FETCH_H);
        cw.arf_funsel  = FUN_INC;
        cw.arf_regsel  = ARF_EN_PC;
      end
      ST_EXEC1: begin
        case (op)
          OP_LDI: begin
            cw.mux_sel_a = MUX_IMM;
            cw.rf_funsel = FUN_LOAD;
            cw.rf_regsel = rf_en(rd);
          end
          OP_LDM, OP_ST: begin
            cw.mux_sel_b  = MUX_IMM;
            cw.arf_funsel = FUN_LOAD;
            cw.arf_regsel = ARF_EN_AR;
          end
          OP_MOV: begin
            cw.alu_funsel = ALU_PASS_B;
            cw.rf_o2sel   = rf_sel(rs);
            cw.mux_sel_a  = MUX_ALU;
            cw.rf_funsel  = FUN_LOAD;
            cw.rf_regsel  = rf_en(rd);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
          OP_NOT, OP_LSL, OP_LSR: begin
            cw.rf_o1sel   = rf_sel(rd);
            cw.rf_o2sel   = rf_sel(rs);
            cw.mux_csel   = 1'b1;
            cw.mux_sel_a  = MUX_ALU;
            cw.rf_funsel  = FUN_LOAD;
            cw.rf_regsel  = rf_en(rd);
            cw.alu_funsel = alu_op_for(op);
          end
          OP_INC, OP_DEC: begin
            cw.rf_funsel = (op == OP_INC) ? FUN_INC : FUN_DEC;
            cw.rf_regsel = rf_en(rd);
          end
          OP_BNE: begin
            // Taken branch reloads PC, replacing the fetch increments
            if (!flag_z) begin
              cw.mux_sel_b  = MUX_IMM;
              cw.arf_funsel = FUN_LOAD;
              cw.arf_regsel = ARF_EN_PC;
            end
          end
          default: ;
        endcase
      end
      ST_EXEC2: begin
        case (op)
          OP_LDM: begin
            cw.arf_outbsel = ARF_AR;
            cw.mem_cs      = 1'b0;
            cw.mux_sel_a   = MUX_MEM;
            cw.rf_funsel   = FUN_LOAD;
            cw.rf_regsel   = rf_en(rd);
          end
          OP_ST: begin
            cw.rf_o1sel    = rf_sel(rd);
            cw.mux_csel    = 1'b1;
            cw.alu_funsel  = ALU_PASS_A;
            cw.arf_outbsel = ARF_AR;
            cw.mem_cs      = 1'b0;
            cw.mem_wr      = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer driving ALU_System controls.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic        ALUFlagZ,
  output logic [2:0]  RF_O1Sel,
  output logic [2:0]  RF_O2Sel,
  output logic [1:0]  RF_FunSel,
  output logic [1:0]  ARF_FunSel,
  output logic [1:0]  IR_Funsel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ARF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxSelA,
  output logic [1:0]  MuxSelB,
  output logic        MuxCSel,
  output logic        Halted,
  output logic [2:0]  State
);

  state_e     state_q, state_d;
  ctrl_t      cw;
  logic [3:0] opcode;
  logic       unused_ir;

  assign opcode    = IROut[15:12];
  assign unused_ir = ^IROut[11:0];

  // State register; reset lands in INIT so the datapath gets cleared first
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Next-state: fetch two bytes, execute, and loop; LDM/ST take an extra cycle
  always_comb begin
    state_d = ST_INIT;
    case (state_q)
      ST_INIT:    state_d = ST_FETCH_L;
      ST_FETCH_L: state_d = ST_FETCH_H;
      ST_FETCH_H: state_d = ST_EXEC1;
      ST_EXEC1: begin
        case (opcode)
          OP_LDM, OP_ST: state_d = ST_EXEC2;
          OP_HLT:        state_d = ST_HALT;
          default:       state_d = ST_FETCH_L;
        endcase
      end
      ST_EXEC2:   state_d = ST_FETCH_L;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_INIT;
    endcase
  end

  ctrl_decoder u_dec (
    .state  (state_q),
    .ir     (IROut),
    .flag_z (ALUFlagZ),
    .cw     (cw)
  );

  assign RF_O1Sel    = cw.rf_o1sel;
  assign RF_O2Sel    = cw.rf_o2sel;
  assign RF_FunSel   = cw.rf_funsel;
  assign ARF_FunSel  = cw.arf_funsel;
  assign IR_Funsel   = cw.ir_funsel;
  assign RF_RegSel   = cw.rf_regsel;
  assign RF_TSel     = cw.rf_tsel;
  assign ARF_RegSel  = cw.arf_regsel;
  assign ALU_FunSel  = cw.alu_funsel;
  assign ARF_OutASel = cw.arf_outasel;
  assign ARF_OutBSel = cw.arf_outbsel;
  assign IR_LH       = cw.ir_lh;
  assign IR_Enable   = cw.ir_enable;
  assign Mem_WR      = cw.mem_wr;
  assign Mem_CS      = cw.mem_cs;
  assign MuxSelA     = cw.mux_sel_a;
  assign MuxSelB     = cw.mux_sel_b;
  assign MuxCSel     = cw.mux_csel;
  assign Halted      = (state_q == ST_HALT);
  assign State       = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Randomized instruction-stream bench for control_unit with a cycle-level reference model.
module tb_control_unit;

  logic        Clock, Reset;
  logic [15:0] IROut;
  logic        ALUFlagZ;
  logic [2:0]  RF_O1Sel, RF_O2Sel, State;
  logic [1:0]  RF_FunSel, ARF_FunSel, IR_Funsel, ARF_OutASel, ARF_OutBSel, MuxSelA, MuxSelB;
  logic [3:0]  RF_RegSel, RF_TSel, ARF_RegSel, ALU_FunSel;
  logic        IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxCSel, Halted;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] o1, o2;
    logic [1:0] rf_fun, arf_fun, ir_fun;
    logic [3:0] rf_reg, rf_t, arf_reg, alu;
    logic [1:0] outa, outb;
    logic       lh, ir_en, wr, cs;
    logic [1:0] mxa, mxb;
    logic       mxc;
  } cw_t;

  cw_t obs;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUFlagZ(ALUFlagZ),
    .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel), .RF_FunSel(RF_FunSel),
    .ARF_FunSel(ARF_FunSel), .IR_Funsel(IR_Funsel), .RF_RegSel(RF_RegSel),
    .RF_TSel(RF_TSel), .ARF_RegSel(ARF_RegSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .IR_LH(IR_LH),
    .IR_Enable(IR_Enable), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .MuxSelA(MuxSelA), .MuxSelB(MuxSelB), .MuxCSel(MuxCSel),
    .Halted(Halted), .State(State)
  );

  assign obs = {RF_O1Sel, RF_O2Sel, RF_FunSel, ARF_FunSel, IR_Funsel, RF_RegSel,
                RF_TSel, ARF_RegSel, ALU_FunSel, ARF_OutASel, ARF_OutBSel,
                IR_LH, IR_Enable, Mem_WR, Mem_CS, MuxSelA, MuxSelB, MuxCSel};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cw_t idle_cw();
    cw_t c;
    c = '0;
    c.rf_reg = 4'hF; c.rf_t = 4'hF; c.arf_reg = 4'hF; c.cs = 1'b1;
    return c;
  endfunction

  // Expected ALU code for each opcode that uses the two-operand ALU path
  function automatic logic [3:0] alu_of(input logic [3:0] op);
    logic [3:0] t [16];
    t = '{4'h0, 4'h0, 4'h0, 4'h1, 4'b0100, 4'b0101, 4'b0111, 4'b1000,
          4'b1010, 4'b0010, 4'b1011, 4'b1100, 4'h0, 4'h0, 4'h0, 4'h0};
    return t[op];
  endfunction

  // Phase: 0 INIT, 1 FETCH_L, 2 FETCH_H, 3 EXEC1, 4 EXEC2, 5 HALT
  function automatic cw_t exp_cw(input int ph, input logic [15:0] ins, input logic z);
    cw_t c;
    int op, rd, rs;
    logic [3:0] dst;
    op  = int'(ins[15:12]);
    rd  = int'(ins[9:8]);
    rs  = int'(ins[1:0]);
    dst = 4'hF;
    dst[rd] = 1'b0;
    c = idle_cw();
    if (ph == 0) begin
      c.arf_reg = 4'b1000; c.rf_reg = 4'b0000;
    end else if (ph == 1 || ph == 2) begin
      c.outb = 2'd3; c.cs = 1'b0; c.ir_en = 1'b1; c.ir_fun = 2'd1;
      c.arf_fun = 2'd3; c.arf_reg = 4'b1110; c.lh = (ph == 2);
    end else if (ph == 3) begin
      if (op == 0) begin
        c.mxa = 2'd2; c.rf_fun = 2'd1; c.rf_reg = dst;
      end else if (op == 1 || op == 2) begin
        c.mxb = 2'd2; c.arf_fun = 2'd1; c.arf_reg = 4'b1101;
      end else if (op == 3) begin
        c.alu = 4'b0001; c.o2 = 3'(rs + 4); c.rf_fun = 2'd1; c.rf_reg = dst;
      end else if (op >= 4 && op <= 11) begin
        c.o1 = 3'(rd + 4); c.o2 = 3'(rs + 4); c.mxc = 1'b1;
        c.rf_fun = 2'd1; c.rf_reg = dst; c.alu = alu_of(ins[15:12]);
      end else if (op == 12 || op == 13) begin
        c.rf_fun = (op == 12) ? 2'd3 : 2'd2; c.rf_reg = dst;
      end else if (op == 14 && !z) begin
        c.mxb = 2'd2; c.arf_fun = 2'd1; c.arf_reg = 4'b1110;
      end
    end else if (ph == 4) begin
      if (op == 1) begin
        c.cs = 1'b0; c.mxa = 2'd1; c.rf_fun = 2'd1; c.rf_reg = dst;
      end else if (op == 2) begin
        c.o1 = 3'(rd + 4); c.mxc = 1'b1; c.cs = 1'b0; c.wr = 1'b1;
      end
    end
    return c;
  endfunction

  // One cycle window: drive inputs after negedge, compare 1 time unit later
  task automatic window(input int ph, input logic [15:0] drv_ir, input logic drv_z,
                        input logic [15:0] ins, input string nm);
    IROut = drv_ir; ALUFlagZ = drv_z;
    #1;
    chk({nm, "_state"}, 64'(State), 64'(ph));
    chk({nm, "_halted"}, 64'(Halted), 64'(ph == 5));
    chk({nm, "_cw"}, 64'(obs), 64'(exp_cw(ph, ins, drv_z)));
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic z, input bit rst_e2);
    logic [3:0] op;
    op = ins[15:12];
    window(1, 16'($urandom), 1'($urandom), ins, "fetch_l"); @(negedge Clock);
    window(2, 16'($urandom), 1'($urandom), ins, "fetch_h"); @(negedge Clock);
    window(3, ins, z, ins, "exec1"); @(negedge Clock);
    if (op == 4'h1 || op == 4'h2) begin
      window(4, ins, 1'($urandom), ins, "exec2");
      if (rst_e2) begin
        #1 Reset = 1'b0;
        #1;
        chk("rst_state", 64'(State), 64'd0);
        chk("rst_halted", 64'(Halted), 64'd0);
        chk("rst_regsel", 64'(RF_RegSel), 64'd0);
        chk("rst_cw", 64'(obs), 64'(exp_cw(0, ins, 1'b0)));
        #1 Reset = 1'b1;
      end
      @(negedge Clock);
    end
    if (op == 4'hF) begin
      for (int i = 0; i < 20; i++) begin
        window(5, 16'($urandom), 1'($urandom), ins, "halt"); @(negedge Clock);
      end
    end
  endtask

  initial begin
    logic [15:0] r;
    Reset = 1'b0; IROut = '0; ALUFlagZ = 1'b0;
    @(negedge Clock);
    window(0, 16'($urandom), 1'($urandom), 16'h0, "init");
    #1 Reset = 1'b1;
    @(negedge Clock);

    run_instr(16'h0142, 1'($urandom), 1'b0);   // LDI R2, 42
    run_instr(16'h4003, 1'($urandom), 1'b0);   // ADD R1, R4
    run_instr(16'h2380, 1'($urandom), 1'b0);   // ST R4 -> 80
    run_instr(16'h1255, 1'($urandom), 1'b1);   // LDM, reset mid-EXEC2
    run_instr(16'hE010, 1'b0, 1'b0);           // BNE taken
    run_instr(16'hE010, 1'b1, 1'b0);           // BNE not taken
    run_instr(16'h3201, 1'($urandom), 1'b0);   // MOV
    run_instr(16'hC100, 1'($urandom), 1'b0);   // INC
    run_instr(16'hD300, 1'($urandom), 1'b0);   // DEC
    run_instr(16'hB302, 1'($urandom), 1'b0);   // LSR

    for (int k = 0; k < 300; k++) begin
      r = 16'($urandom);
      if (r[15:12] == 4'hF) r[15:12] = 4'(k % 15);
      run_instr(r, 1'($urandom), (k % 50) == 7);
    end

    run_instr(16'hF000, 1'($urandom), 1'b0);   // HLT, then 20 halted cycles

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired fetch/decode/execute sequencer that sits directly upstream of `ALU_System` and drives every one of its control inputs. It reads the 16-bit instruction word back from the IR and the Z flag back from the ALU. The datapath registers have no reset, so after reset the block first clears them, then loops fetch → execute. Control outputs are a combinational decode of the current state plus the latched instruction.

## Interface
- No parameters.
- `Clock` in 1: system clock. All state updates on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `IROut` in 16: instruction word read back from the IR.
- `ALUFlagZ` in 1: ALU zero flag (OutFlag[3]).
- `RF_O1Sel`, `RF_O2Sel` out 3 each: RegFile output selects. 4–7 select R1–R4.
- `RF_FunSel`, `ARF_FunSel`, `IR_Funsel` out 2 each: register function. 0 clear, 1 load, 2 decrement, 3 increment.
- `RF_RegSel`, `RF_TSel`, `ARF_RegSel` out 4 each: active-low enables.
  - RF_RegSel bit i enables R(i+1).
  - ARF_RegSel bit0 = PC, bit1 = AR, bit2 = SP.
- `ALU_FunSel` out 4: ALU operation.
- `ARF_OutASel`, `ARF_OutBSel` out 2 each: 0 AR, 1 SP, 3 PC.
- `IR_LH` out 1, `IR_Enable` out 1: IR half select and enable.
- `Mem_WR` out 1, `Mem_CS` out 1: memory control. `Mem_CS` is active-low.
- `MuxSelA`, `MuxSelB` out 2 each: 0 ALU, 1 memory, 2 IR[7:0], 3 ARF OutA.
- `MuxCSel` out 1: 1 = RF O1, 0 = ARF OutA.
- `Halted` out 1: high in HALT.
- `State` out 3: current state, for debug.

## Operation
**Idle control word.** This is the default, and every output not listed for a state takes it:
- all RegSel/TSel = 4'hF, ARF_RegSel = 4'hF
- IR_Enable = 0, Mem_CS = 1, Mem_WR = 0
- all selects and FunSels = 0

**Instruction fields.** IR[15:12] opcode; IR[9:8] Rd; IR[1:0] Rs; IR[7:0] immediate or address.

**States.** INIT=0, FETCH_L=1, FETCH_H=2, EXEC1=3, EXEC2=4, HALT=5.

**INIT.**
- Clear PC, AR, SP: ARF_FunSel=0, ARF_RegSel=4'b1000.
- Clear R1–R4: RF_FunSel=0, RF_RegSel=0.
- Next state: FETCH_L.

**FETCH_L** (loads the low byte, IR_LH=0) and **FETCH_H** (loads the high byte, IR_LH=1). Both states drive:
- Memory read at PC: ARF_OutBSel=3, Mem_CS=0, Mem_WR=0.
- IR load: IR_Enable=1, IR_Funsel=1.
- PC increment: ARF_FunSel=3, ARF_RegSel=4'b1110.
- Next state: FETCH_L → FETCH_H → EXEC1.

**EXEC1, by opcode.** Unless noted, the instruction finishes here and the next state is FETCH_L.
- 0 LDI: Rd ← IR[7:0]. MuxSelA=2, RF_FunSel=1, Rd enabled.
- 1 LDM and 2 ST: AR ← IR[7:0]. MuxSelB=2, ARF_FunSel=1, ARF_RegSel=4'b1101. Next state EXEC2.
- 3 MOV: ALU pass-B (0001). O2Sel=Rs+4, MuxSelA=0, load Rd.
- 4–8 two-register ALU ops:
  - Common controls: O1Sel=Rd+4, O2Sel=Rs+4, MuxCSel=1, MuxSelA=0, RF_FunSel=1, Rd enabled.
  - ALU_FunSel: ADD 0100, SUB 0101, AND 0111, OR 1000, XOR 1010.
- 9–B unary ALU ops on Rd, same controls as 4–8:
  - NOT 0010
  - LSL 1011
  - LSR 1100
- C INC and D DEC: RF_FunSel=3 (INC) or 2 (DEC), Rd enabled.
- E BNE: if ALUFlagZ=0, PC ← IR[7:0] (MuxSelB=2, ARF_FunSel=1, ARF_RegSel=4'b1110). Otherwise the idle word.
- F HLT: next state HALT.

**EXEC2.** Next state is FETCH_L.
- LDM: Rd ← M[AR]. ARF_OutBSel=0, Mem_CS=0, MuxSelA=1, RF_FunSel=1, Rd enabled.
- ST: M[AR] ← Rd. O1Sel=Rd+4, MuxCSel=1, ALU_FunSel=0000, ARF_OutBSel=0, Mem_CS=0, Mem_WR=1.

**HALT.** Idle word, Halted=1. Stays in HALT until reset.

## Timing
- `Reset` low asserts immediately, including mid-instruction: State=INIT, outputs = INIT word, Halted=0.
- Instruction latency:
  - LDI, ALU ops, INC/DEC, MOV, BNE: 3 cycles (FETCH_L, FETCH_H, EXEC1).
  - LDM, ST: 4 cycles.
- PC advances by 2 per fetch. PC wraps 8'hFF → 8'h00 with no special handling.
- BNE samples ALUFlagZ combinationally in EXEC1. The ALU updates flags on the falling edge, so the Z of the previous ALU op is stable by the EXEC1 rising edge.
- A taken BNE overrides the PC increments of the same fetch. The next fetch is from IR[7:0].
- IROut is used only in EXEC1 and EXEC2. It is stable there because IR_Enable=0.
- Undefined state encodings 6 and 7 go to INIT.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - the state enum
  - the opcode constants
  - the ALU_FunSel, register FunSel, mux-select and ARF-select constants (reused by `ALU_System` benches)
- One sub-module, `ctrl_decoder`: purely combinational, mapping (State, IROut, ALUFlagZ) → control word.
- The top holds the state register and next-state logic.

## Test plan
- **Reset.** Reset low mid-EXEC2 → State=0 and RF_RegSel=0 immediately. One cycle after release → State=1, Mem_CS=0, ARF_OutBSel=3.
- **LDI.** IROut=16'h0142 (R2 ← 8'h42) → in EXEC1: MuxSelA=2, RF_FunSel=1, RF_RegSel=4'b1101. State then 1.
- **ADD.** IROut=16'h4003 (R1 ← R1 + R4) → ALU_FunSel=0100, O1Sel=4, O2Sel=7, MuxCSel=1, RF_RegSel=4'b1110.
- **ST.** IROut=16'h2380 → EXEC1: ARF_RegSel=4'b1101, MuxSelB=2. EXEC2: Mem_WR=1, Mem_CS=0, O1Sel=7, ARF_OutBSel=0.
- **BNE.** IROut=16'hE010 with Z=0 → ARF_RegSel=4'b1110, ARF_FunSel=1. With Z=1 → ARF_RegSel=4'hF.
- **HLT.** IROut=16'hF000 → Halted=1 from the next cycle. Holds for 20 cycles with all outputs idle.
